ssd_reg_bus_arbiter: RTL and testbench
======================================

Name: ssd_reg_bus_arbiter

Overview:
- Shares the single SSD-controller register bus (active-low wr_n/rd_n strobes, 9-bit addr, 32-bit wdata/rdata) between NUM_REQ internal requesters, e.g. host Avalon bridge, DMA descriptor engine and status poller.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the strobe and captures read data after a fixed RD_LAT cycles.
- Sits between the requesters and the register-file slave.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_W, 9, register address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from rd_n low edge to rdata valid at slave output (1..4)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  NUM_REQ  per-requester transaction request
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- req_ready  out  NUM_REQ  one-hot accept pulse
- rsp_valid  out  NUM_REQ  one-hot completion pulse (writes and reads)
- rsp_rdata  out  DATA_W  read data, shared, valid with rsp_valid
- wr_n  out  1  register write strobe, active low
- rd_n  out  1  register read strobe, active low
- addr  out  ADDR_W  register address
- wdata  out  DATA_W  register write data
- rdata  in  DATA_W  register read data

Behaviour:
- Reset values:
  - wr_n=1, rd_n=1, addr=0, wdata=0
  - req_ready=0, rsp_valid=0, rsp_rdata=0
  - state=IDLE, rr pointer=0
- All outputs are registered.
- IDLE:
  - If any req_valid, grant the first valid index searching from the pointer upward with wrap.
  - Assert req_ready[g] for 1 cycle.
  - Latch write/addr/wdata of g; go to ISSUE.
  - Pointer becomes g+1 mod NUM_REQ.
  - Requester may drop req_valid after seeing req_ready.
- ISSUE:
  - Drive addr/wdata and exactly one strobe low for exactly 1 cycle.
  - Write: go to RESP.
  - Read: go to RDWAIT with counter=RD_LAT.
- RDWAIT:
  - Strobes high; addr held. Decrement counter each cycle.
  - At counter=1, register rdata into rsp_rdata; go to RESP.
- RESP:
  - rsp_valid[g]=1 for 1 cycle; rsp_rdata holds the captured value until the next read capture.
  - Return to IDLE.
- Latency, req_ready to rsp_valid:
  - Write: 2 cycles.
  - Read: 2+RD_LAT cycles.
  - Back-to-back throughput: 1 write per 3 cycles.
- addr and wdata hold their last values while idle; the strobes are the only qualifiers.
- Requests arriving during a transaction wait; req_valid must be held until req_ready. A dropped request is never granted.
- A single requester continuously valid is served every transaction.
- All NUM_REQ valid: grants rotate strictly i, i+1, …
- A requester issuing a new request in the same cycle as its rsp_valid is legal; it is considered in the next IDLE.
- Reset mid-transaction:
  - Strobes return high immediately (async).
  - No rsp_valid is produced for the aborted transaction.
- req_write sampled only at grant.

Optional Feature:
- REG_BUS_REQ0_PRIO_EN defined: requester 0 has strict priority; whenever req_valid[0]=1 in IDLE it is granted. The rr pointer is not advanced by a requester-0 grant; the others rotate round-robin among themselves.
- Undefined: pure round-robin as above.

Decomposition:
- Package ssd_reg_bus_pkg:
  - state enum {IDLE, ISSUE, RDWAIT, RESP}
  - REG_ADDR_W=9, REG_DATA_W=32 constants
  - a clog2-based index-width function
- Sub-module ssd_rr_arbiter: combinational grant from valid vector + pointer, with priority-0 override under the macro. The FSM and bus registers stay in the top.

Test Plan:
- Single write: req_valid[0], write, addr=0x01A, wdata=0xDEADBEEF → req_ready[0] 1 cycle, next cycle wr_n=0 with addr=0x01A/wdata=0xDEADBEEF for exactly 1 cycle, rd_n=1 throughout, rsp_valid[0] 1 cycle later.
- Read RD_LAT=1: slave model returns 0x12345678 for addr 0x100 → rd_n low 1 cycle, rsp_valid[1] with rsp_rdata=0x12345678 at grant+3; repeat with RD_LAT=3 → grant+5.
- Contention, NUM_REQ=4, all valid continuously, 8 transactions → grant order 0,1,2,3,0,1,2,3; never two strobes low simultaneously.
- Fairness after pointer move: grant 2 alone, then req 0 and 3 valid together → 3 granted first, then 0.
- Reset asserted while rd_n=0 → rd_n/wr_n high same cycle, no rsp_valid, after release first grant goes to index 0.
- REG_BUS_REQ0_PRIO_EN build: req 0 re-asserted every IDLE with req 1,2 valid → requester 0 granted each time; when req 0 idle, 1 then 2 alternate.

Source files
------------

// File: rtl/ssd_reg_bus_pkg.sv
// Shared types and constants for the SSD register-bus arbiter.
package ssd_reg_bus_pkg;

    localparam int unsigned REG_ADDR_W = 9;
    localparam int unsigned REG_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StResp
    } bus_state_e;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ssd_rr_arbiter.sv
// Combinational round-robin grant search starting at the pointer, with wrap.
// REG_BUS_REQ0_PRIO_EN: requester 0 wins outright and leaves the pointer alone.
module ssd_rr_arbiter
    import ssd_reg_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdxW   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IdxW-1:0]    ptr_i,
    output logic               grant_vld_o,
    output logic [IdxW-1:0]    grant_idx_o,
    output logic               adv_ptr_o
);

    always_comb begin
        int unsigned s;
        logic [IdxW-1:0] idx;
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        adv_ptr_o   = 1'b1;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            s = 32'(ptr_i) + k;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            idx = IdxW'(s);
            if (!grant_vld_o && valid_i[idx]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = idx;
            end
        end
`ifdef REG_BUS_REQ0_PRIO_EN
        if (valid_i[0]) begin
            grant_vld_o = 1'b1;
            grant_idx_o = '0;
            adv_ptr_o   = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/ssd_reg_bus_arbiter.sv
// Shares one SSD-controller register bus among NUM_REQ requesters, one transaction at a time.
// Build with REG_BUS_REQ0_PRIO_EN to give requester 0 strict priority.
module ssd_reg_bus_arbiter
    import ssd_reg_bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      wr_n_o,
    output logic                      rd_n_o,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [DATA_W-1:0]         wdata_o,
    input  logic [DATA_W-1:0]         rdata_i
);

    localparam int unsigned IdxW = idx_w(NUM_REQ);
    localparam int unsigned CntW = 3;

    bus_state_e          state_q, state_d;
    logic [IdxW-1:0]     ptr_q, ptr_d;
    logic [IdxW-1:0]     gidx_q, gidx_d;
    logic                is_wr_q, is_wr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d, rsp_valid_q, rsp_valid_d;

    logic                grant_vld, adv_ptr;
    logic [IdxW-1:0]     grant_idx;
    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr_i[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = req_wdata_i[i*DATA_W +: DATA_W];
        end
    end

    ssd_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .valid_i     (req_valid_i),
        .ptr_i       (ptr_q),
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx),
        .adv_ptr_o   (adv_ptr)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        is_wr_d     = is_wr_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_n_d      = 1'b1;
        rd_n_d      = 1'b1;
        ready_d     = '0;
        rsp_valid_d = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    ready_d[grant_idx] = 1'b1;
                    gidx_d  = grant_idx;
                    is_wr_d = req_write_i[grant_idx];
                    addr_d  = addr_arr[grant_idx];
                    wdata_d = wdata_arr[grant_idx];
                    if (adv_ptr) begin
                        ptr_d = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (is_wr_q) begin
                    wr_n_d  = 1'b0;
                    state_d = StResp;
                end else begin
                    rd_n_d  = 1'b0;
                    cnt_d   = CntW'(RD_LAT);
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q - CntW'(1);
                // Slave data is valid on the last wait cycle; grab it then.
                if (cnt_q == CntW'(1)) begin
                    rsp_rdata_d = rdata_i;
                    state_d     = StResp;
                end
            end
            StResp: begin
                rsp_valid_d[gidx_q] = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            gidx_q      <= '0;
            is_wr_q     <= 1'b0;
            cnt_q       <= '0;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            ready_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            is_wr_q     <= is_wr_d;
            cnt_q       <= cnt_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign wr_n_o      = wr_n_q;
    assign rd_n_o      = rd_n_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_ssd_reg_bus_arbiter.sv
// Bench for ssd_reg_bus_arbiter: transaction-level timeline model plus a latency-strict slave.
module tb_ssd_reg_bus_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, wdata, rdata;
    logic            wr_n, rd_n;
    logic [AW-1:0]   addr;

    always #5 clk = ~clk;

    ssd_reg_bus_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RD_LAT  (RL)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .wr_n_o      (wr_n),
        .rd_n_o      (rd_n),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .rdata_i     (rdata)
    );

    function automatic logic [31:0] slave_data(input logic [8:0] a);
        if (a == 9'h100) return 32'h1234_5678;
        return {a, 23'h0} ^ 32'h5A5A_C3C3 ^ {23'h0, a};
    endfunction

    // Slave drives valid data only in the cycle exactly RL cycles after the rd_n low edge.
    int sc, elapsed;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           sc <= 0;
        else if (!rd_n)       sc <= 1;
        else if (sc != 0)     sc <= sc + 1;
    end
    always_comb begin
        elapsed = !rd_n ? 1 : ((sc != 0) ? sc + 1 : 0);
        rdata   = (elapsed == RL) ? slave_data(addr) : 32'hDEAD_0BAD;
    end

    int n_tests = 0, n_fail = 0;
    int n = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    // Reference model: one transaction record, events placed on an absolute cycle timeline.
    int          ptr_m, g_m, gedge, rsp_edge, free_at;
    bit          act, wr_m, hold_valid;
    logic [8:0]  addr_m;
    logic [31:0] wdata_m, rdata_m;
    logic [NR-1:0] e_ready, e_rsp;
    logic        e_wr_n, e_rd_n;

    task automatic model_reset();
        act = 0; ptr_m = 0; free_at = n + 1;
        addr_m = '0; wdata_m = '0; rdata_m = '0;
    endtask

    task automatic model_step();
        int g;
        e_ready = '0; e_rsp = '0; e_wr_n = 1'b1; e_rd_n = 1'b1;
        if (act) begin
            if (n == gedge + 1) begin
                if (wr_m) e_wr_n = 1'b0; else e_rd_n = 1'b0;
            end
            if (!wr_m && n == gedge + 1 + RL) rdata_m = slave_data(addr_m);
            if (n == rsp_edge) begin
                e_rsp[g_m] = 1'b1;
                act = 0;
                free_at = n + 1;
            end
        end
        if (!act && n >= free_at && req_valid != '0) begin
            g = -1;
`ifdef REG_BUS_REQ0_PRIO_EN
            if (req_valid[0]) g = 0;
`endif
            for (int k = 0; k < NR && g < 0; k++)
                if (req_valid[(ptr_m + k) % NR]) g = (ptr_m + k) % NR;
            act = 1; g_m = g; gedge = n;
            wr_m = req_write[g];
            addr_m = req_addr[g*AW +: AW];
            wdata_m = req_wdata[g*DW +: DW];
            rsp_edge = n + 2 + (wr_m ? 0 : RL);
            e_ready[g] = 1'b1;
`ifdef REG_BUS_REQ0_PRIO_EN
            if (g != 0) ptr_m = (g + 1) % NR;
`else
            ptr_m = (g + 1) % NR;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        model_step();
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        check("wr_n", 32'(wr_n), 32'(e_wr_n));
        check("rd_n", 32'(rd_n), 32'(e_rd_n));
        check("addr", 32'(addr), 32'(addr_m));
        check("wdata", wdata, wdata_m);
        check("rsp_rdata", rsp_rdata, rdata_m);
        for (int i = 0; i < NR; i++)
            if (e_ready[i] && !hold_valid) req_valid[i] = 1'b0;
    endtask

    task automatic set_req(input int i, input bit w, input logic [8:0] a, input logic [31:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic check_reset_vals();
        check("rst_wr_n", 32'(wr_n), 32'd1);
        check("rst_rd_n", 32'(rd_n), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_wdata", wdata, 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
    endtask

    initial begin
        bit seen_rd;
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        hold_valid = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst_n = 1'b1;
        model_reset();

        // Single write, then a read of the slave's 0x100 location.
        set_req(0, 1'b1, 9'h01A, 32'hDEAD_BEEF);
        repeat (6) tick();
        set_req(1, 1'b0, 9'h100, 32'h0);
        repeat (10) tick();

        // All requesters held valid: strict rotation.
        hold_valid = 1;
        for (int i = 0; i < NR; i++) set_req(i, i[0], 9'(i * 3 + 5), 32'hA000_0000 + i);
        repeat (8 * (3 + RL)) tick();
        hold_valid = 0;
        req_valid = '0;
        repeat (8) tick();

        // Pointer moves past 2, then 0 and 3 compete.
        set_req(2, 1'b1, 9'h022, 32'h2222_2222);
        repeat (6) tick();
        set_req(0, 1'b1, 9'h000, 32'h0000_0F0F);
        set_req(3, 1'b0, 9'h033, 32'h0);
        repeat (14) tick();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            tick();
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), 9'($urandom), $urandom);
        end
        req_valid = '0;
        repeat (10) tick();

        // Reset while rd_n is low.
        set_req(1, 1'b0, 9'h0AB, 32'h0);
        seen_rd = 0;
        for (int k = 0; k < 10 && !seen_rd; k++) begin
            tick();
            seen_rd = !e_rd_n;
        end
        check("rd_strobe_seen", 32'(seen_rd), 32'd1);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("async_rd_n", 32'(rd_n), 32'd1);
        check("async_wr_n", 32'(wr_n), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check_reset_vals();
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 9'(i + 1), 32'hC0DE_0000 + i);
        repeat (20) tick();
        req_valid = '0;
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
